// File: rtl/sort4_seq.sv
// Four-sample sequential sorter: load four samples, sort them with one shared
// greater-than comparator over six fixed compare-and-swap steps, then stream them out.
module sort4_seq #(
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          busy,
  output logic [2:0]    swap_count
);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] r_q [4];
  logic [DW-1:0] r_d [4];
  logic [1:0]    wp_q, wp_d;
  logic [1:0]    rp_q, rp_d;
  logic [2:0]    step_q, step_d;
  logic [2:0]    swap_q, swap_d;

  logic [1:0]    lo_idx;
  logic [1:0]    hi_idx;
  logic [DW-1:0] cmp_a;
  logic [DW-1:0] cmp_b;
  logic          cmp_gt;

  // Bubble schedule (0,1),(1,2),(2,3),(0,1),(1,2),(0,1) as the lower index of each pair.
  always_comb begin
    lo_idx = 2'd0;
    case (step_q)
      3'd1, 3'd4: lo_idx = 2'd1;
      3'd2:       lo_idx = 2'd2;
      default:    lo_idx = 2'd0;
    endcase
  end

  assign hi_idx = lo_idx + 2'd1;
  assign cmp_a  = r_q[lo_idx];
  assign cmp_b  = r_q[hi_idx];
  assign cmp_gt = cmp_a > cmp_b;

  always_comb begin
    state_d = state_q;
    for (int i = 0; i < 4; i++) r_d[i] = r_q[i];
    wp_d   = wp_q;
    rp_d   = rp_q;
    step_d = step_q;
    swap_d = swap_q;
    case (state_q)
      LOAD: begin
        if (in_valid) begin
          r_d[wp_q] = in_data;
          wp_d      = wp_q + 2'd1;
          if (wp_q == 2'd0) swap_d = 3'd0;
          if (wp_q == 2'd3) begin
            state_d = SORT;
            step_d  = 3'd0;
            wp_d    = 2'd0;
          end
        end
      end
      SORT: begin
        // Strict compare keeps ties in place, so equal samples never swap.
        if (cmp_gt) begin
          r_d[lo_idx] = cmp_b;
          r_d[hi_idx] = cmp_a;
          swap_d      = swap_q + 3'd1;
        end
        if (step_q == 3'd5) begin
          state_d = DRAIN;
          step_d  = 3'd0;
          rp_d    = 2'd0;
        end else begin
          step_d = step_q + 3'd1;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          rp_d = rp_q + 2'd1;
          if (rp_q == 2'd3) state_d = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= LOAD;
      for (int i = 0; i < 4; i++) r_q[i] <= '0;
      wp_q   <= 2'd0;
      rp_q   <= 2'd0;
      step_q <= 3'd0;
      swap_q <= 3'd0;
    end else begin
      state_q <= state_d;
      for (int i = 0; i < 4; i++) r_q[i] <= r_d[i];
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      step_q <= step_d;
      swap_q <= swap_d;
    end
  end

  assign in_ready   = (state_q == LOAD);
  assign out_valid  = (state_q == DRAIN);
  assign busy       = (state_q != LOAD);
  assign out_data   = out_valid ? r_q[rp_q] : '0;
  assign swap_count = swap_q;

endmodule

// File: tb/tb_sort4_seq.sv
// Self-checking bench for sort4_seq: directed and random batches compared against
// a sorted-queue / inversion-count model of the sorter.
module tb_sort4_seq;

  localparam int DW = 4;
  typedef logic [DW-1:0] batch_t [4];

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          busy;
  logic [2:0]    swap_count;

  int checks     = 0;
  int errors     = 0;
  int prev_swaps = 0;

  sort4_seq #(.DW(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy),
    .swap_count (swap_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Starts at a falling edge in LOAD; returns at the falling edge after the 4th accept.
  task automatic loadBatch(input batch_t vals);
    for (int i = 0; i < 4; i++) begin
      checkOutput("in_ready_load", {31'd0, in_ready}, 1);
      if (i == 0) checkOutput("swap_hold", {29'd0, swap_count}, prev_swaps);
      in_valid = 1'b1;
      in_data  = vals[i];
      @(negedge clk);
      if (i == 0) checkOutput("swap_clear", {29'd0, swap_count}, 0);
    end
    in_valid = 1'b0;
  endtask

  task automatic applyStimulus(input batch_t vals, input bit garbage, input bit bp);
    int q[$];
    int inv;
    int cnt;
    int busy_cycles;
    inv = 0;
    for (int i = 0; i < 4; i++) begin
      for (int j = i + 1; j < 4; j++) if (vals[i] > vals[j]) inv++;
      q.push_back(int'(vals[i]));
    end
    q.sort();

    loadBatch(vals);
    if (garbage) begin
      in_valid = 1'b1;
      in_data  = '1;
    end
    cnt = 0;
    busy_cycles = 0;
    while (out_valid !== 1'b1 && cnt < 20) begin
      if (busy === 1'b1) busy_cycles++;
      checkOutput("in_ready_sort", {31'd0, in_ready}, 0);
      checkOutput("out_data_sort", {28'd0, out_data}, 0);
      @(negedge clk);
      cnt++;
    end
    checkOutput("sort_latency", cnt, 6);

    for (int k = 0; k < 4; k++) begin
      if (bp && k == 2) begin
        out_ready = 1'b0;
        repeat (3) begin
          if (busy === 1'b1) busy_cycles++;
          checkOutput("bp_valid", {31'd0, out_valid}, 1);
          checkOutput("bp_data", {28'd0, out_data}, q[k]);
          @(negedge clk);
        end
        out_ready = 1'b1;
      end
      if (busy === 1'b1) busy_cycles++;
      checkOutput("out_valid", {31'd0, out_valid}, 1);
      checkOutput("out_data", {28'd0, out_data}, q[k]);
      checkOutput("in_ready_drain", {31'd0, in_ready}, 0);
      checkOutput("swap_count", {29'd0, swap_count}, inv);
      @(negedge clk);
    end
    in_valid = 1'b0;
    checkOutput("in_ready_after", {31'd0, in_ready}, 1);
    checkOutput("out_valid_after", {31'd0, out_valid}, 0);
    checkOutput("out_data_after", {28'd0, out_data}, 0);
    checkOutput("busy_after", {31'd0, busy}, 0);
    checkOutput("busy_cycles", busy_cycles, bp ? 13 : 10);
    prev_swaps = inv;
  endtask

  initial begin
    batch_t b;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    #2;
    checkOutput("rst_in_ready", {31'd0, in_ready}, 1);
    checkOutput("rst_out_valid", {31'd0, out_valid}, 0);
    checkOutput("rst_out_data", {28'd0, out_data}, 0);
    checkOutput("rst_busy", {31'd0, busy}, 0);
    checkOutput("rst_swap", {29'd0, swap_count}, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] directed batches");
    b = '{4'd3, 4'd1, 4'd2, 4'd0};   applyStimulus(b, 1'b0, 1'b0);
    b = '{4'd1, 4'd2, 4'd3, 4'd4};   applyStimulus(b, 1'b0, 1'b0);
    b = '{4'd15, 4'd10, 4'd5, 4'd0}; applyStimulus(b, 1'b0, 1'b0);
    b = '{4'd7, 4'd7, 4'd7, 4'd7};   applyStimulus(b, 1'b0, 1'b0);
    b = '{4'd9, 4'd4, 4'd9, 4'd4};   applyStimulus(b, 1'b1, 1'b1);

    $display("[TB] reset during sort");
    b = '{4'd12, 4'd3, 4'd8, 4'd1};
    loadBatch(b);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("midrst_in_ready", {31'd0, in_ready}, 1);
    checkOutput("midrst_out_valid", {31'd0, out_valid}, 0);
    checkOutput("midrst_busy", {31'd0, busy}, 0);
    checkOutput("midrst_swap", {29'd0, swap_count}, 0);
    @(negedge clk);
    reset = 1'b0;
    prev_swaps = 0;
    @(negedge clk);
    b = '{4'd2, 4'd0, 4'd3, 4'd1};   applyStimulus(b, 1'b0, 1'b0);

    $display("[TB] random batches");
    repeat (8) begin
      for (int i = 0; i < 4; i++) b[i] = DW'($urandom_range(0, 15));
      applyStimulus(b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
